// File: rtl/microcode_loader_pkg.sv
// Shared definitions for the microcode loader: frame header byte, RAM geometry
// defaults and the loader FSM state encoding.
package microcode_loader_pkg;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int         AW_DEF    = 6;
  localparam int         DW_DEF    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ADDR,
    ST_DATA,
    ST_CSUM
  } state_t;

endpackage

// File: rtl/microcode_loader_ram.sv
// Microcode store: 2**AW x DW array with one synchronous write port and one
// asynchronous read port (a same-cycle read of the written address sees the old word).
module microcode_ram
  import microcode_loader_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/microcode_loader.sv
// Framed byte-stream writer for the microcode RAM plus the decode-side lookup.
// Frame: MAGIC, COUNT, ADDR, COUNT data bytes, CSUM (XOR of the data bytes).
module microcode_loader
  import microcode_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC = MAGIC_DEF,
  parameter int         AW    = AW_DEF,
  parameter int         DW    = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  input  logic [7:0]    opcode_i,
  output logic [DW-1:0] q_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          ucode_valid_o
);

  localparam logic [8:0] CNT_MAX = 9'(2**AW);

  state_t        state_q, state_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] xacc_q, xacc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic          we;
  logic          accept;
  logic [DW-1:0] rd_data;
  logic          unused_opcode;

  assign rx_ready_o = ~rst_i;
  assign accept     = rx_valid_i & rx_ready_o;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    xacc_d  = xacc_q;
    done_d  = 1'b0;
    err_d   = err_q;
    valid_d = valid_q;
    we      = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data_i == MAGIC) begin
            state_d = ST_COUNT;
            err_d   = 1'b0;
            valid_d = 1'b0;
          end
        end
        ST_COUNT: begin
          if (rx_data_i == 8'd0 || {1'b0, rx_data_i} > CNT_MAX) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            rem_d   = rx_data_i[AW:0];
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if ((rx_data_i >> AW) != 8'd0) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            ptr_d   = rx_data_i[AW-1:0];
            xacc_d  = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // An out-of-range data byte aborts before anything reaches the RAM.
          if ((rx_data_i >> DW) != 8'd0) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            we     = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            xacc_d = xacc_q ^ rx_data_i[DW-1:0];
            rem_d  = rem_q - 1'b1;
            if (rem_q == {{AW{1'b0}}, 1'b1}) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (rx_data_i == {{(8-DW){1'b0}}, xacc_q}) begin
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
      xacc_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      xacc_q  <= xacc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  microcode_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk_i),
    .we   (we),
    .waddr(ptr_q),
    .wdata(rx_data_i[DW-1:0]),
    .raddr(opcode_i[AW-1:0]),
    .rdata(rd_data)
  );

  // Opcodes with the top bit set bypass the table; the bits between the table
  // index and the top bit do not take part in the lookup.
  assign q_o           = opcode_i[7] ? '1 : rd_data;
  assign unused_opcode = ^opcode_i[7:AW];

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign ucode_valid_o = valid_q;

endmodule

// File: tb/tb_microcode_loader.sv
// Self-checking bench for microcode_loader: directed frames plus randomized
// frame streams checked against a frame-level reference model.
module tb_microcode_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] opcode_i = 8'h00;
  logic [2:0] q_o;
  logic       busy_o, done_o, err_o, ucode_valid_o;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  int exp_dones = 0;

  logic [2:0] mref [64];
  bit         known [64];
  bit         exp_err, exp_valid, exp_busy;

  microcode_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .opcode_i     (opcode_i),
    .q_o          (q_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .ucode_valid_o(ucode_valid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o === 1'b1) done_seen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Frame-level model: walks the byte list by index, applying frame rules.
  task automatic model_stream(input bq_t s);
    int i, n, cnt, addr, b, k, x;
    bit bad;
    i = 0;
    n = s.size();
    while (i < n) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      exp_err = 0; exp_valid = 0; exp_busy = 1;
      if (i + 1 >= n) return;
      cnt = int'(s[i+1]);
      if (cnt == 0 || cnt > 64) begin
        exp_err = 1; exp_busy = 0; i += 2;
        continue;
      end
      if (i + 2 >= n) return;
      addr = int'(s[i+2]);
      if (addr > 63) begin
        exp_err = 1; exp_busy = 0; i += 3;
        continue;
      end
      x = 0; bad = 0; k = 0;
      while (k < cnt && !bad) begin
        if (i + 3 + k >= n) return;
        b = int'(s[i+3+k]);
        if (b > 7) bad = 1;
        else begin
          mref[(addr + k) % 64] = 3'(b);
          known[(addr + k) % 64] = 1;
          x ^= b;
          k++;
        end
      end
      if (bad) begin
        exp_err = 1; exp_busy = 0; i = i + 3 + k + 1;
        continue;
      end
      if (i + 3 + cnt >= n) return;
      if (int'(s[i+3+cnt]) == x) begin
        exp_valid = 1; exp_dones++;
      end else begin
        exp_err = 1;
      end
      exp_busy = 0;
      i += 4 + cnt;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic send_stream(input bq_t s, input bit gaps, input bit do_model);
    foreach (s[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          rx_data_i = 8'hA5;
          @(posedge clk_i);
          #1;
        end
      end
      send_byte(s[i]);
    end
    if (do_model) model_stream(s);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_checks++; if (rx_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0", rx_ready_o); end
    n_checks++; if ({busy_o, done_o, err_o, ucode_valid_o} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy_o, done_o, err_o, ucode_valid_o}); end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    n_checks++; if (rx_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_after_reset: got %b want 1", rx_ready_o); end
    exp_err = 0; exp_valid = 0; exp_busy = 0;
  endtask

  task automatic test_good_frame();
    send_stream('{8'hA5, 8'h02, 8'h05, 8'h03, 8'h06, 8'h05}, 1'b0, 1'b1);
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL good_done: got %b want 1", done_o); end
    n_checks++; if (ucode_valid_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL good_flags: got v=%b e=%b b=%b want 1 0 0", ucode_valid_o, err_o, busy_o); end
    opcode_i = 8'h05; #1;
    n_checks++; if (q_o !== 3'b011) begin n_fail++; $display("[TB] FAIL good_q5: got %b want 011", q_o); end
    opcode_i = 8'h06; #1;
    n_checks++; if (q_o !== 3'b110) begin n_fail++; $display("[TB] FAIL good_q6: got %b want 110", q_o); end
    opcode_i = 8'h45; #1;
    n_checks++; if (q_o !== 3'b011) begin n_fail++; $display("[TB] FAIL bit6_ignored: got %b want 011", q_o); end
    @(posedge clk_i); #1;
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL done_one_cycle: got %b want 0", done_o); end
  endtask

  task automatic test_rw_hazard();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
    opcode_i   = 8'h05;
    rx_data_i  = 8'h04;
    rx_valid_i = 1'b1;
    #1;
    n_checks++; if (q_o !== 3'b011) begin n_fail++; $display("[TB] FAIL hazard_old: got %b want 011", q_o); end
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
    n_checks++; if (q_o !== 3'b100) begin n_fail++; $display("[TB] FAIL hazard_new: got %b want 100", q_o); end
    send_byte(8'h04);
    model_stream('{8'hA5, 8'h01, 8'h05, 8'h04, 8'h04});
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL hazard_done: got %b want 1", done_o); end
  endtask

  task automatic test_wrap();
    send_stream('{8'hA5, 8'h02, 8'h3F, 8'h01, 8'h02, 8'h03}, 1'b0, 1'b1);
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_done: got %b want 1", done_o); end
    opcode_i = 8'h3F; #1;
    n_checks++; if (q_o !== 3'b001) begin n_fail++; $display("[TB] FAIL wrap_q63: got %b want 001", q_o); end
    opcode_i = 8'h00; #1;
    n_checks++; if (q_o !== 3'b010) begin n_fail++; $display("[TB] FAIL wrap_q0: got %b want 010", q_o); end
    opcode_i = 8'h80; #1;
    n_checks++; if (q_o !== 3'b111) begin n_fail++; $display("[TB] FAIL bypass_80: got %b want 111", q_o); end
    opcode_i = 8'hBF; #1;
    n_checks++; if (q_o !== 3'b111) begin n_fail++; $display("[TB] FAIL bypass_bf: got %b want 111", q_o); end
  endtask

  task automatic test_bad_csum();
    send_stream('{8'hA5, 8'h01, 8'h00, 8'h04, 8'h00}, 1'b0, 1'b1);
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL badcs_done: got %b want 0", done_o); end
    n_checks++; if (err_o !== 1'b1 || ucode_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL badcs_flags: got e=%b v=%b b=%b want 1 0 0", err_o, ucode_valid_o, busy_o); end
    opcode_i = 8'h00; #1;
    n_checks++; if (q_o !== 3'b100) begin n_fail++; $display("[TB] FAIL badcs_ram0: got %b want 100", q_o); end
    @(negedge clk_i); #1;
    n_checks++; if (done_seen !== exp_dones) begin n_fail++; $display("[TB] FAIL badcs_done_count: got %0d want %0d", done_seen, exp_dones); end
    send_stream('{8'hA5}, 1'b0, 1'b0);
    n_checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL magic_clears_err: got e=%b b=%b want 0 1", err_o, busy_o); end
    send_stream('{8'h01, 8'h00, 8'h04, 8'h04}, 1'b0, 1'b0);
    model_stream('{8'hA5, 8'h01, 8'h00, 8'h04, 8'h04});
    n_checks++; if (ucode_valid_o !== exp_valid) begin n_fail++; $display("[TB] FAIL badcs_recover: got %b want %b", ucode_valid_o, exp_valid); end
  endtask

  task automatic test_illegal();
    send_stream('{8'hA5, 8'h00}, 1'b0, 1'b1);
    n_checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL count0: got e=%b b=%b want 1 0", err_o, busy_o); end
    send_stream('{8'hA5, 8'h01, 8'h40}, 1'b0, 1'b1);
    n_checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL addr40: got e=%b b=%b want 1 0", err_o, busy_o); end
    send_stream('{8'hA5, 8'h02, 8'h07, 8'h01, 8'h01, 8'h00}, 1'b0, 1'b1);
    send_stream('{8'hA5, 8'h02, 8'h07, 8'h05, 8'h08}, 1'b0, 1'b1);
    n_checks++; if (err_o !== 1'b1 || busy_o !== 1'b0 || ucode_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL data08: got e=%b b=%b v=%b want 1 0 0", err_o, busy_o, ucode_valid_o); end
    opcode_i = 8'h07; #1;
    n_checks++; if (q_o !== 3'b101) begin n_fail++; $display("[TB] FAIL data08_prev_written: got %b want 101", q_o); end
    opcode_i = 8'h08; #1;
    n_checks++; if (q_o !== 3'b001) begin n_fail++; $display("[TB] FAIL data08_not_written: got %b want 001", q_o); end
  endtask

  task automatic test_gaps_junk();
    send_stream('{8'hA5, 8'h02, 8'h05, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1);
    send_stream('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h05, 8'h03, 8'h06, 8'h05}, 1'b1, 1'b1);
    n_checks++; if (done_o !== 1'b1 || ucode_valid_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL gaps_flags: got d=%b v=%b e=%b want 1 1 0", done_o, ucode_valid_o, err_o); end
    opcode_i = 8'h05; #1;
    n_checks++; if (q_o !== 3'b011) begin n_fail++; $display("[TB] FAIL gaps_q5: got %b want 011", q_o); end
    opcode_i = 8'h06; #1;
    n_checks++; if (q_o !== 3'b110) begin n_fail++; $display("[TB] FAIL gaps_q6: got %b want 110", q_o); end
  endtask

  task automatic test_reset_mid();
    send_stream('{8'hA5, 8'h02, 8'h10, 8'h05}, 1'b0, 1'b1);
    n_checks++; if (busy_o !== exp_busy) begin n_fail++; $display("[TB] FAIL mid_busy: got %b want %b", busy_o, exp_busy); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_err = 0; exp_valid = 0; exp_busy = 0;
    n_checks++; if ({busy_o, err_o, ucode_valid_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL mid_reset_flags: got %b want 000", {busy_o, err_o, ucode_valid_o}); end
    opcode_i = 8'h10; #1;
    n_checks++; if (q_o !== 3'b101) begin n_fail++; $display("[TB] FAIL mid_reset_persist: got %b want 101", q_o); end
  endtask

  task automatic test_random();
    bq_t s;
    int  j, kind, cnt, addr, x, d, bad_k;
    for (int it = 0; it < 24; it++) begin
      s = {};
      repeat ($urandom_range(0, 2)) begin
        j = $urandom_range(0, 255);
        if (j == 8'hA5) j = 0;
        s.push_back(8'(j));
      end
      kind = $urandom_range(0, 7);
      cnt  = $urandom_range(1, 64);
      addr = $urandom_range(0, 63);
      s.push_back(8'hA5);
      if (kind == 0) s.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(65, 100)));
      else s.push_back(8'(cnt));
      s.push_back(kind == 1 ? 8'($urandom_range(64, 127)) : 8'(addr));
      x = 0;
      bad_k = $urandom_range(0, cnt - 1);
      for (int k = 0; k < cnt; k++) begin
        d = $urandom_range(0, 7);
        if (kind == 2 && k == bad_k) d = $urandom_range(8, 127);
        else x ^= d;
        s.push_back(8'(d));
      end
      s.push_back(kind == 3 ? 8'(x ^ $urandom_range(1, 7)) : 8'(x));
      send_stream(s, 1'b1, 1'b1);
      @(negedge clk_i); #1;
      n_checks++; if ({err_o, ucode_valid_o, busy_o} !== {exp_err, exp_valid, exp_busy}) begin n_fail++; $display("[TB] FAIL rand_flags it=%0d: got e/v/b=%b want %b", it, {err_o, ucode_valid_o, busy_o}, {exp_err, exp_valid, exp_busy}); end
      n_checks++; if (done_seen !== exp_dones) begin n_fail++; $display("[TB] FAIL rand_done_count it=%0d: got %0d want %0d", it, done_seen, exp_dones); end
    end
    for (int a = 0; a < 64; a++) begin
      if (known[a]) begin
        opcode_i = {1'b0, 1'($urandom), 6'(a)}; #1;
        n_checks++; if (q_o !== mref[a]) begin n_fail++; $display("[TB] FAIL rand_ram[%0d]: got %b want %b", a, q_o, mref[a]); end
      end
    end
    repeat (4) begin
      opcode_i = {1'b1, 7'($urandom)}; #1;
      n_checks++; if (q_o !== 3'b111) begin n_fail++; $display("[TB] FAIL rand_bypass op=%h: got %b want 111", opcode_i, q_o); end
    end
  endtask

  initial begin
    foreach (known[i]) known[i] = 0;
    test_reset();
    test_good_frame();
    test_rw_hazard();
    test_wrap();
    test_bad_csum();
    test_illegal();
    test_gaps_junk();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
